// File: rtl/hpdcache_plru_mp_pkg.sv
// hpdcache_repl_pkg: replacement classes, clear FSM states and LFSR constants
package hpdcache_repl_pkg;
  typedef enum logic [2:0] {UNUSED = 3'd0, PLRU = 3'd1, CLEAN = 3'd2, DIRTY = 3'd3, NONE = 3'd4} hpdcache_repl_class_e;
  typedef enum logic {IDLE, SWEEP} hpdcache_repl_fsm_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/hpdcache_plru_mp_if.sv
// hpdcache_plru_mp_if: update, refill, victim-select and clear signals of the PLRU unit
interface hpdcache_plru_mp_if
  import hpdcache_repl_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int NUPDT = 2
);
  localparam int SW = $clog2(SETS);
  logic [NUPDT-1:0]      updt_i;
  logic [NUPDT*SW-1:0]   updt_set_i;
  logic [NUPDT*WAYS-1:0] updt_way_i;
  logic                  repl_i;
  logic [SW-1:0]         repl_set_i;
  logic [WAYS-1:0]       repl_way_i;
  logic                  sel_req_i;
  logic [SW-1:0]         sel_set_i;
  logic [WAYS-1:0]       sel_dir_valid_i;
  logic [WAYS-1:0]       sel_dir_dirty_i;
  logic [WAYS-1:0]       sel_dir_fetch_i;
  logic                  sel_valid_o;
  logic [WAYS-1:0]       sel_victim_way_o;
  hpdcache_repl_class_e  sel_class_o;
  logic                  sel_none_o;
  logic                  clr_req_i;
  logic                  clr_ready_o;
  modport master (
    output updt_i, updt_set_i, updt_way_i, repl_i, repl_set_i, repl_way_i,
    output sel_req_i, sel_set_i, sel_dir_valid_i, sel_dir_dirty_i, sel_dir_fetch_i, clr_req_i,
    input  sel_valid_o, sel_victim_way_o, sel_class_o, sel_none_o, clr_ready_o
  );
  modport slave (
    input  updt_i, updt_set_i, updt_way_i, repl_i, repl_set_i, repl_way_i,
    input  sel_req_i, sel_set_i, sel_dir_valid_i, sel_dir_dirty_i, sel_dir_fetch_i, clr_req_i,
    output sel_valid_o, sel_victim_way_o, sel_class_o, sel_none_o, clr_ready_o
  );
endinterface

// File: rtl/hpdcache_plru_mp_rot_pick.sv
// hpdcache_repl_rot_pick: one-hot grant of the first request at or after ptr, wrapping around
module hpdcache_repl_rot_pick #(
  parameter  int N  = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW-1:0] idx;
  // scan from the farthest slot back to ptr so the nearest request overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hpdcache_plru_mp.sv
// hpdcache_plru_mp: multi-port bit-PLRU with victim select and clear sweep; HPDCACHE_PLRU_MP_LFSR_EN enables rotating priority
module hpdcache_plru_mp
  import hpdcache_repl_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int NUPDT = 2
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_plru_mp_if.slave bus
);
  localparam int SW = $clog2(SETS);
  localparam int PW = $clog2(WAYS);
  logic [WAYS-1:0] plru_q [SETS];
  logic [WAYS-1:0] plru_d [SETS];
  logic [WAYS-1:0] acc [SETS];
  logic [WAYS-1:0] nxt [SETS];
  hpdcache_repl_fsm_e fsm_q;
  logic [SW-1:0] cnt_q;
  logic ready_q;
  logic [WAYS-1:0] cur, v, d, f, m_unused, m_plru, m_clean, m_dirty;
  logic [WAYS-1:0] g_unused, g_plru, g_clean, g_dirty, way_d, way_q;
  logic [PW-1:0] ptr;
  hpdcache_repl_class_e cls_d, cls_q;
  logic valid_q, none_q;
  // merge every port and the refill per set; saturation restarts from the newest accesses
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      acc[s] = (bus.repl_i && bus.repl_set_i == SW'(s)) ? bus.repl_way_i : '0;
      for (int p = 0; p < NUPDT; p++)
        acc[s] = acc[s] | ((bus.updt_i[p] && bus.updt_set_i[p*SW +: SW] == SW'(s)) ? bus.updt_way_i[p*WAYS +: WAYS] : '0);
      nxt[s] = plru_q[s] | acc[s];
      plru_d[s] = &nxt[s] ? (&acc[s] ? '0 : acc[s]) : nxt[s];
    end
  end
  // PLRU state: the sweep clears one set per cycle and drops all updates meanwhile
  always_ff @(posedge clk_i) begin
    if (rst_i) for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    else if (fsm_q == SWEEP) plru_q[cnt_q] <= '0;
    else plru_q <= plru_d;
  end
  // clear FSM with a registered ready flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b1;
    end else if (fsm_q == IDLE) begin
      if (bus.clr_req_i) begin
        fsm_q <= SWEEP;
        cnt_q <= '0;
        ready_q <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == SW'(SETS - 1)) begin
        fsm_q <= IDLE;
        ready_q <= 1'b1;
      end
    end
  end
`ifdef HPDCACHE_PLRU_MP_LFSR_EN
  logic [15:0] lfsr_q;
  assign ptr = lfsr_q[PW-1:0];
  // rotation pointer source, stepped once per victim request
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else if (bus.sel_req_i) lfsr_q <= lfsr_next(lfsr_q);
  end
`else
  assign ptr = '0;
`endif
  assign cur = plru_q[bus.sel_set_i];
  assign v = bus.sel_dir_valid_i;
  assign d = bus.sel_dir_dirty_i;
  assign f = bus.sel_dir_fetch_i;
  assign m_unused = ~v & ~f;
  assign m_plru = v & ~f & ~cur;
  assign m_clean = v & ~f & ~d;
  assign m_dirty = v & ~f & d;
  hpdcache_repl_rot_pick #(.N(WAYS)) u_unused (.req(m_unused), .ptr(PW'(0)), .gnt(g_unused));
  hpdcache_repl_rot_pick #(.N(WAYS)) u_plru (.req(m_plru), .ptr(ptr), .gnt(g_plru));
  hpdcache_repl_rot_pick #(.N(WAYS)) u_clean (.req(m_clean), .ptr(ptr), .gnt(g_clean));
  hpdcache_repl_rot_pick #(.N(WAYS)) u_dirty (.req(m_dirty), .ptr(ptr), .gnt(g_dirty));
  // class priority; the dirty grant is already zero when nothing is selectable
  always_comb begin
    cls_d = |m_unused ? UNUSED : |m_plru ? PLRU : |m_clean ? CLEAN : |m_dirty ? DIRTY : NONE;
    way_d = |m_unused ? g_unused : |m_plru ? g_plru : |m_clean ? g_clean : g_dirty;
  end
  // victim result register, one cycle after the request, using pre-update state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      way_q <= '0;
      cls_q <= NONE;
      none_q <= 1'b0;
    end else begin
      valid_q <= bus.sel_req_i;
      if (bus.sel_req_i) begin
        way_q <= way_d;
        cls_q <= cls_d;
        none_q <= cls_d == NONE;
      end
    end
  end
  assign bus.sel_valid_o = valid_q;
  assign bus.sel_victim_way_o = way_q;
  assign bus.sel_class_o = cls_q;
  assign bus.sel_none_o = none_q;
  assign bus.clr_ready_o = ready_q;
endmodule

// File: tb/tb_hpdcache_plru_mp.sv
// tb_hpdcache_plru_mp: scoreboard bench with a set-level reference model of the PLRU unit
module tb_hpdcache_plru_mp;
  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int NUPDT = 2;
  localparam int SW = $clog2(SETS);
  typedef struct {
    bit [WAYS-1:0] way;
    int cls;
    bit none;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  hpdcache_plru_mp_if #(.SETS(SETS), .WAYS(WAYS), .NUPDT(NUPDT)) bus ();
  hpdcache_plru_mp #(.SETS(SETS), .WAYS(WAYS), .NUPDT(NUPDT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  bit [WAYS-1:0] m_plru [SETS];
  bit m_sweep;
  int m_cnt;
  bit [15:0] m_lfsr = 16'hACE1;
  exp_t q[$];
  bit exp_valid, exp_ready = 1'b1, mon_en;
  int errors, checks;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t pick(bit [WAYS-1:0] pl, bit [WAYS-1:0] v, bit [WAYS-1:0] d, bit [WAYS-1:0] f, int ptr);
    bit [WAYS-1:0] m[4];
    exp_t e;
    int w;
    m[0] = ~v & ~f;
    m[1] = v & ~f & ~pl;
    m[2] = v & ~f & ~d;
    m[3] = v & ~f & d;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < WAYS; k++) begin
        w = (c == 0) ? k : (ptr + k) % WAYS;
        if (m[c][w]) begin
          e.way = '0;
          e.way[w] = 1'b1;
          e.cls = c;
          e.none = 1'b0;
          return e;
        end
      end
    e.way = '0;
    e.cls = 4;
    e.none = 1'b1;
    return e;
  endfunction
  task automatic idle();
    bus.updt_i = '0;
    bus.updt_set_i = '0;
    bus.updt_way_i = '0;
    bus.repl_i = 1'b0;
    bus.repl_set_i = '0;
    bus.repl_way_i = '0;
    bus.sel_req_i = 1'b0;
    bus.sel_set_i = '0;
    bus.sel_dir_valid_i = '0;
    bus.sel_dir_dirty_i = '0;
    bus.sel_dir_fetch_i = '0;
    bus.clr_req_i = 1'b0;
  endtask
  task automatic updt(input int p, input int s, input int w);
    bus.updt_i[p] = 1'b1;
    bus.updt_set_i[p*SW +: SW] = SW'(s);
    bus.updt_way_i[p*WAYS +: WAYS] = WAYS'(1) << w;
  endtask
  task automatic sel(input int s, input bit [WAYS-1:0] v, input bit [WAYS-1:0] d, input bit [WAYS-1:0] f);
    bus.sel_req_i = 1'b1;
    bus.sel_set_i = SW'(s);
    bus.sel_dir_valid_i = v;
    bus.sel_dir_dirty_i = d;
    bus.sel_dir_fetch_i = f;
  endtask
  // advance the model by one clock from the inputs currently driven, then wait for the next negedge
  task automatic step();
    bit [WAYS-1:0] a, n;
    int ptr;
    ptr = 0;
`ifdef HPDCACHE_PLRU_MP_LFSR_EN
    ptr = int'(m_lfsr) % WAYS;
`endif
    exp_valid = !rst && bus.sel_req_i;
    if (exp_valid) begin
      q.push_back(pick(m_plru[bus.sel_set_i], bus.sel_dir_valid_i, bus.sel_dir_dirty_i, bus.sel_dir_fetch_i, ptr));
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    if (rst) begin
      foreach (m_plru[s]) m_plru[s] = '0;
      m_sweep = 1'b0;
      m_lfsr = 16'hACE1;
    end else if (m_sweep) begin
      m_plru[m_cnt] = '0;
      if (m_cnt == SETS - 1) m_sweep = 1'b0;
      else m_cnt++;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        a = (bus.repl_i && int'(bus.repl_set_i) == s) ? bus.repl_way_i : '0;
        for (int p = 0; p < NUPDT; p++)
          if (bus.updt_i[p] && int'(bus.updt_set_i[p*SW +: SW]) == s) a |= bus.updt_way_i[p*WAYS +: WAYS];
        n = m_plru[s] | a;
        if (n == '1) n = (a == '1) ? '0 : a;
        m_plru[s] = n;
      end
      if (bus.clr_req_i) begin
        m_sweep = 1'b1;
        m_cnt = 0;
      end
    end
    exp_ready = !m_sweep;
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("sel_valid", int'(bus.sel_valid_o), int'(exp_valid));
        chk("clr_ready", int'(bus.clr_ready_o), int'(exp_ready));
        if (bus.sel_valid_o) begin
          if (q.size() == 0) chk("unexpected_victim", 1, 0);
          else begin
            e = q.pop_front();
            chk("victim_way", int'(bus.sel_victim_way_o), int'(e.way));
            chk("victim_class", int'(bus.sel_class_o), e.cls);
            chk("victim_none", int'(bus.sel_none_o), int'(e.none));
          end
        end
      end
    end
  end
  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_way", int'(bus.sel_victim_way_o), 0);
    chk("reset_class", int'(bus.sel_class_o), 4);
    chk("reset_none", int'(bus.sel_none_o), 0);
    sel(3, 4'b0000, 4'b0000, 4'b0000); step(); idle();
    updt(0, 5, 0); updt(1, 5, 1); step(); idle();
    updt(0, 5, 2); step(); idle();
    sel(5, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    updt(1, 5, 3); step(); idle();
    sel(5, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    updt(0, 2, 0); updt(1, 2, 1);
    bus.repl_i = 1'b1; bus.repl_set_i = SW'(9); bus.repl_way_i = 4'b0100;
    step(); idle();
    sel(2, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    sel(9, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    sel(1, 4'b1111, 4'b0000, 4'b1111); step(); idle();
    updt(0, 7, 0); updt(1, 7, 1); step(); idle();
    updt(0, 7, 2); step(); idle();
    sel(7, 4'b1111, 4'b1000, 4'b0000); step(); idle();
    bus.clr_req_i = 1'b1; step(); idle();
    for (int i = 0; i < SETS + 2; i++) begin
      updt(0, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
      bus.clr_req_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sel($urandom_range(0, SETS - 1), 4'b1111, 4'($urandom), 4'b0000);
      step(); idle();
    end
    for (int s = 0; s < SETS; s++) begin
      sel(s, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    end
    bus.clr_req_i = 1'b1; step(); idle();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      sel(0, 4'b1111, 4'b0000, 4'b0000); step(); idle();
    end
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.clr_req_i = $urandom_range(0, 199) == 0;
      for (int p = 0; p < NUPDT; p++)
        if ($urandom_range(0, 1)) updt(p, $urandom_range(0, 7), $urandom_range(0, WAYS - 1));
      if ($urandom_range(0, 2) == 0) begin
        bus.repl_i = 1'b1;
        bus.repl_set_i = SW'($urandom_range(0, 7));
        bus.repl_way_i = WAYS'(1) << $urandom_range(0, WAYS - 1);
      end
      if ($urandom_range(0, 1)) sel($urandom_range(0, 7), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      step(); idle();
      rst = 1'b0;
    end
    step();
    step();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
